// File: rtl/decode_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_ctrl_stage
// Description : RV32I decode/control stage with a valid/ready output register,
//               flush, and a load-use interlock. Define RV32M_EN to decode the
//               M-extension ops; otherwise they are reported as illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_ctrl_stage #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int PC_W             = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_aluop,
    output logic            out_rf_en,
    output logic            out_sel_b,
    output logic            out_is_load,
    output logic            out_mem_write,
    output logic            out_load_unsigned,
    output logic [1:0]      out_mem_size,
    output logic            out_is_branch,
    output logic            out_is_jal,
    output logic            out_is_jalr,
    output logic            out_is_lui,
    output logic            out_is_auipc,
    output logic [2:0]      out_br_funct3,
    output logic            out_illegal,
    output logic            hazard_stall
);

    localparam logic [1:0] c_bubbles   = 2'(LOAD_USE_BUBBLES);
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_reg    = 7'b0110011;
    localparam logic [4:0] c_alu_sub   = 5'd1;
    localparam logic [4:0] c_alu_sra   = 5'd9;
    localparam logic [4:0] c_alu_passb = 5'd10;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [4:0] w_rd, w_rs1, w_rs2;

    assign w_opcode = in_instr[6:0];
    assign w_rd     = in_instr[11:7];
    assign w_funct3 = in_instr[14:12];
    assign w_rs1    = in_instr[19:15];
    assign w_rs2    = in_instr[24:20];
    assign w_funct7 = in_instr[31:25];

    logic [4:0] w_aluop;
    logic       w_rf_en, w_sel_b, w_is_load, w_mem_write, w_load_unsigned;
    logic [1:0] w_mem_size;
    logic       w_is_branch, w_is_jal, w_is_jalr, w_is_lui, w_is_auipc;
    logic [2:0] w_br_funct3;
    logic       w_legal, w_use_rs1, w_use_rs2;

    // funct3 -> ALU op for the funct7=0000000 row shared by OP and OP-IMM
    function automatic logic [4:0] base_op(input logic [2:0] f3);
        case (f3)
            3'd0:    base_op = 5'd0;
            3'd1:    base_op = 5'd7;
            3'd2:    base_op = 5'd5;
            3'd3:    base_op = 5'd6;
            3'd4:    base_op = 5'd4;
            3'd5:    base_op = 5'd8;
            3'd6:    base_op = 5'd3;
            default: base_op = 5'd2;
        endcase
    endfunction

    always_comb begin
        w_aluop = '0; w_rf_en = 1'b0; w_sel_b = 1'b0; w_is_load = 1'b0;
        w_mem_write = 1'b0; w_load_unsigned = 1'b0; w_mem_size = '0;
        w_is_branch = 1'b0; w_is_jal = 1'b0; w_is_jalr = 1'b0;
        w_is_lui = 1'b0; w_is_auipc = 1'b0; w_br_funct3 = '0;
        w_legal = 1'b1; w_use_rs1 = 1'b0; w_use_rs2 = 1'b0;
        case (w_opcode)
            c_op_lui: begin
                w_aluop = c_alu_passb; w_sel_b = 1'b1; w_rf_en = 1'b1; w_is_lui = 1'b1;
            end
            c_op_auipc: begin
                w_sel_b = 1'b1; w_rf_en = 1'b1; w_is_auipc = 1'b1;
            end
            c_op_jal: begin
                w_rf_en = 1'b1; w_is_jal = 1'b1;
            end
            c_op_jalr: begin
                w_legal = (w_funct3 == 3'b000);
                w_sel_b = 1'b1; w_rf_en = 1'b1; w_is_jalr = 1'b1; w_use_rs1 = 1'b1;
            end
            c_op_branch: begin
                w_legal = (w_funct3[2:1] != 2'b01);
                w_aluop = c_alu_sub; w_is_branch = 1'b1; w_br_funct3 = w_funct3;
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            end
            c_op_load: begin
                w_legal = (w_funct3 != 3'b011) && (w_funct3[2:1] != 2'b11);
                w_sel_b = 1'b1; w_rf_en = 1'b1; w_is_load = 1'b1; w_use_rs1 = 1'b1;
                w_mem_size = w_funct3[1:0]; w_load_unsigned = w_funct3[2];
            end
            c_op_store: begin
                w_legal = (w_funct3 < 3'b011);
                w_sel_b = 1'b1; w_mem_write = 1'b1; w_mem_size = w_funct3[1:0];
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            end
            c_op_imm: begin
                w_sel_b = 1'b1; w_rf_en = 1'b1; w_use_rs1 = 1'b1;
                w_aluop = base_op(w_funct3);
                if (w_funct3 == 3'b001) begin
                    w_legal = (w_funct7 == 7'b0000000);
                end else if (w_funct3 == 3'b101) begin
                    w_legal = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
                    if (w_funct7 == 7'b0100000) w_aluop = c_alu_sra;
                end
            end
            c_op_reg: begin
                w_rf_en = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                case (w_funct7)
                    7'b0000000: w_aluop = base_op(w_funct3);
                    7'b0100000: begin
                        if (w_funct3 == 3'b000)      w_aluop = c_alu_sub;
                        else if (w_funct3 == 3'b101) w_aluop = c_alu_sra;
                        else                         w_legal = 1'b0;
                    end
`ifdef RV32M_EN
                    7'b0000001: w_aluop = {2'b10, w_funct3};
`endif
                    default:    w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
        if (in_instr[1:0] != 2'b11) w_legal = 1'b0;
        // An illegal word still issues, but with every side effect suppressed
        if (!w_legal) begin
            w_aluop = '0; w_rf_en = 1'b0; w_sel_b = 1'b0; w_is_load = 1'b0;
            w_mem_write = 1'b0; w_load_unsigned = 1'b0; w_mem_size = '0;
            w_is_branch = 1'b0; w_is_jal = 1'b0; w_is_jalr = 1'b0;
            w_is_lui = 1'b0; w_is_auipc = 1'b0; w_br_funct3 = '0;
            w_use_rs1 = 1'b0; w_use_rs2 = 1'b0;
        end
    end

    logic [1:0] r_cnt;
    logic [4:0] r_ld_rd;
    logic       w_adv, w_dep, w_accept;

    assign w_adv        = !out_valid || out_ready;
    assign w_dep        = in_valid && (r_cnt != 2'd0) &&
                          ((w_use_rs1 && (w_rs1 == r_ld_rd)) || (w_use_rs2 && (w_rs2 == r_ld_rd)));
    assign hazard_stall = w_dep && !flush;
    assign in_ready     = w_adv && !hazard_stall && !flush && !rst;
    assign w_accept     = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0; out_pc <= '0; out_rd <= '0; out_rs1 <= '0; out_rs2 <= '0;
            out_aluop <= '0; out_rf_en <= 1'b0; out_sel_b <= 1'b0; out_is_load <= 1'b0;
            out_mem_write <= 1'b0; out_load_unsigned <= 1'b0; out_mem_size <= '0;
            out_is_branch <= 1'b0; out_is_jal <= 1'b0; out_is_jalr <= 1'b0;
            out_is_lui <= 1'b0; out_is_auipc <= 1'b0; out_br_funct3 <= '0;
            out_illegal <= 1'b0; r_cnt <= '0; r_ld_rd <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            r_cnt     <= '0;
        end else if (w_adv) begin
            out_valid <= w_accept;
            if (w_accept) begin
                out_pc <= in_pc; out_rd <= w_rd; out_rs1 <= w_rs1; out_rs2 <= w_rs2;
                out_aluop <= w_aluop; out_rf_en <= w_rf_en; out_sel_b <= w_sel_b;
                out_is_load <= w_is_load; out_mem_write <= w_mem_write;
                out_load_unsigned <= w_load_unsigned; out_mem_size <= w_mem_size;
                out_is_branch <= w_is_branch; out_is_jal <= w_is_jal; out_is_jalr <= w_is_jalr;
                out_is_lui <= w_is_lui; out_is_auipc <= w_is_auipc;
                out_br_funct3 <= w_br_funct3; out_illegal <= !w_legal;
            end
            // Counts issue slots (real or bubble), never stalled cycles
            if (w_accept && w_is_load && (w_rd != 5'd0)) begin
                r_cnt   <= c_bubbles;
                r_ld_rd <= w_rd;
            end else if (r_cnt != 2'd0) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_ctrl_stage
// Description : Randomized bench for decode_ctrl_stage against a slot-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_ctrl_stage;

    localparam int LUB = 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2, aluop;
        logic        rf_en, sel_b, is_load, mem_write, load_unsigned;
        logic [1:0]  mem_size;
        logic        is_branch, is_jal, is_jalr, is_lui, is_auipc;
        logic [2:0]  br_funct3;
        logic        illegal;
    } bundle_t;

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0, hazard_stall;
    logic [31:0] in_instr = '0, in_pc = '0, out_pc;
    logic [4:0]  out_rd, out_rs1, out_rs2, out_aluop;
    logic        out_rf_en, out_sel_b, out_is_load, out_mem_write, out_load_unsigned;
    logic [1:0]  out_mem_size;
    logic        out_is_branch, out_is_jal, out_is_jalr, out_is_lui, out_is_auipc;
    logic [2:0]  out_br_funct3;
    logic        out_illegal;

    always #5 clk = ~clk;

    decode_ctrl_stage #(.LOAD_USE_BUBBLES(LUB), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_aluop(out_aluop),
        .out_rf_en(out_rf_en), .out_sel_b(out_sel_b), .out_is_load(out_is_load),
        .out_mem_write(out_mem_write), .out_load_unsigned(out_load_unsigned),
        .out_mem_size(out_mem_size), .out_is_branch(out_is_branch),
        .out_is_jal(out_is_jal), .out_is_jalr(out_is_jalr), .out_is_lui(out_is_lui),
        .out_is_auipc(out_is_auipc), .out_br_funct3(out_br_funct3),
        .out_illegal(out_illegal), .hazard_stall(hazard_stall)
    );

    bundle_t dut_b;
    assign dut_b = {out_pc, out_rd, out_rs1, out_rs2, out_aluop, out_rf_en, out_sel_b,
                    out_is_load, out_mem_write, out_load_unsigned, out_mem_size,
                    out_is_branch, out_is_jal, out_is_jalr, out_is_lui, out_is_auipc,
                    out_br_funct3, out_illegal};

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: issue slots since the last load, not a down-counter
    bundle_t     m_b = '0;
    bit          m_valid = 1'b0;
    logic [4:0]  m_ld_rd = '0;
    int          m_since = LUB;
    logic [31:0] pc_q = 32'h100;
    logic [4:0]  r_ops [8] = '{5'd0, 5'd7, 5'd5, 5'd6, 5'd4, 5'd8, 5'd3, 5'd2};

    function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                       output bundle_t b, output bit u1, output bit u2);
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        bit ok = 1'b1;
        b = '0; u1 = 1'b0; u2 = 1'b0;
        b.pc = pc; b.rd = ins[11:7]; b.rs1 = ins[19:15]; b.rs2 = ins[24:20];
        case (ins[6:0])
            7'h37: begin b.aluop = 5'd10; b.sel_b = 1; b.rf_en = 1; b.is_lui = 1; end
            7'h17: begin b.sel_b = 1; b.rf_en = 1; b.is_auipc = 1; end
            7'h6F: begin b.rf_en = 1; b.is_jal = 1; end
            7'h67: begin ok = (f3 == 0); b.sel_b = 1; b.rf_en = 1; b.is_jalr = 1; u1 = 1; end
            7'h63: begin
                ok = !(f3 == 2 || f3 == 3); b.aluop = 5'd1; b.is_branch = 1;
                b.br_funct3 = f3; u1 = 1; u2 = 1;
            end
            7'h03: begin
                ok = !(f3 == 3 || f3 == 6 || f3 == 7); b.is_load = 1; b.rf_en = 1;
                b.sel_b = 1; b.mem_size = f3[1:0]; b.load_unsigned = f3[2]; u1 = 1;
            end
            7'h23: begin ok = (f3 < 3); b.mem_write = 1; b.sel_b = 1; b.mem_size = f3[1:0]; u1 = 1; u2 = 1; end
            7'h13: begin
                b.sel_b = 1; b.rf_en = 1; u1 = 1; b.aluop = r_ops[f3];
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) begin ok = (f7 == 0 || f7 == 7'h20); if (f7 == 7'h20) b.aluop = 5'd9; end
            end
            7'h33: begin
                b.rf_en = 1; u1 = 1; u2 = 1;
                if (f7 == 0) b.aluop = r_ops[f3];
                else if (f7 == 7'h20 && f3 == 0) b.aluop = 5'd1;
                else if (f7 == 7'h20 && f3 == 5) b.aluop = 5'd9;
`ifdef RV32M_EN
                else if (f7 == 7'h01) b.aluop = 5'd16 + 5'(f3);
`endif
                else ok = 1'b0;
            end
            default: ok = 1'b0;
        endcase
        if (ins[1:0] != 2'b11) ok = 1'b0;
        if (!ok) begin
            b = '0; b.pc = pc; b.rd = ins[11:7]; b.rs1 = ins[19:15]; b.rs2 = ins[24:20];
            b.illegal = 1'b1; u1 = 1'b0; u2 = 1'b0;
        end
    endfunction

    task automatic step(input bit v, input logic [31:0] ins, input bit ordy, input bit fl);
        bundle_t e; bit u1, u2, dep, adv, e_stall, e_ready;
        @(negedge clk);
        in_valid = v; in_instr = ins; in_pc = pc_q; out_ready = ordy; flush = fl;
        #1;
        ref_decode(ins, pc_q, e, u1, u2);
        dep = v && (m_since < LUB) && ((u1 && e.rs1 == m_ld_rd) || (u2 && e.rs2 == m_ld_rd));
        adv = !m_valid || ordy;
        e_stall = dep && !fl;
        e_ready = adv && !e_stall && !fl;
        check("hazard_stall", hazard_stall, e_stall);
        check("in_ready", in_ready, e_ready);
        @(posedge clk);
        if (fl) begin
            m_valid = 1'b0; m_since = LUB;
        end else if (adv) begin
            m_valid = v && e_ready;
            if (m_valid) begin m_b = e; pc_q += 4; end
            if (m_valid && e.is_load && e.rd != 0) begin m_ld_rd = e.rd; m_since = 0; end
            else m_since++;
        end
        #1;
        check("out_valid", out_valid, m_valid);
        check("bundle", dut_b, m_b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_bundle", dut_b, '0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_stall", hazard_stall, 1'b0);
        m_valid = 1'b0; m_b = '0; m_since = LUB; m_ld_rd = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
        #1;
        check("rdy_after_rst", in_ready, 1'b1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
        logic [6:0]  f7s [4]  = '{7'h00, 7'h20, 7'h01, 7'h00};
        logic [31:0] w;
        if ($urandom_range(0, 15) == 0) return $urandom();
        w[6:0]   = ops[$urandom_range(0, 9)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[14:12] = 3'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        w[31:25] = ($urandom_range(0, 7) == 0) ? 7'($urandom()) : f7s[$urandom_range(0, 3)];
        return w;
    endfunction

    localparam logic [31:0] ADD3  = 32'h002081B3;
    localparam logic [31:0] LW5   = 32'h0000A283;
    localparam logic [31:0] ADD6  = 32'h00228333;
    localparam logic [31:0] ADDI7 = 32'h00100393;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("init_valid", out_valid, 1'b0);
        check("init_bundle", dut_b, '0);
        check("init_in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("init_rdy_release", in_ready, 1'b1);

        step(1, ADD3, 1, 0);
        check("add_aluop", out_aluop, 5'd0);
        check("add_rf_en", out_rf_en, 1'b1);
        check("add_rd", out_rd, 5'd3);

        step(1, LW5, 1, 0);
        step(1, ADD6, 1, 0);
        check("lu_bubble", out_valid, 1'b0);
        step(1, ADD6, 1, 0);
        check("lu_issue", out_rd, 5'd6);

        step(1, LW5, 1, 0);
        step(1, ADDI7, 1, 0);
        step(1, ADD6, 1, 0);
        check("indep_no_bubble", out_valid, 1'b1);

        step(1, ADD3, 1, 0);
        repeat (3) step(1, ADDI7, 0, 0);
        step(1, ADDI7, 1, 0);
        step(1, ADD6, 1, 0);

        step(1, LW5, 1, 0);
        step(1, ADD6, 1, 1);
        step(1, ADD6, 1, 0);
        check("flush_no_bubble", out_valid, 1'b1);

        step(1, LW5, 1, 0);
        do_reset();
        step(1, ADD6, 1, 0);

        step(1, 32'h022081B3, 1, 0);
`ifdef RV32M_EN
        check("mul_aluop", out_aluop, 5'd16);
`else
        check("mul_illegal", out_illegal, 1'b1);
        check("mul_rf_en", out_rf_en, 1'b0);
`endif
        step(1, 32'h00000000, 1, 0);
        check("zero_illegal", out_illegal, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            step($urandom_range(0, 3) != 0, rand_instr(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_ctrl_stage.md
# decode_ctrl_stage

Registered decode/control stage for the 3-stage RV32 pipeline, sitting between fetch and execute. It decodes the full RV32I instruction word into a control bundle with a wider ALU op space and illegal-instruction detection. The bundle is held in a valid/ready pipeline register with flush. A parametrised load-use interlock inserts bubbles automatically.

## Interface
Parameters:
- `LOAD_USE_BUBBLES`, default 1: bubbles required between a load and a dependent instruction. Legal range 0–3; 0 disables the interlock.
- `PC_W`, default 32: PC width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  PC_W  PC of `in_instr`.
- `flush`  in  1  kill register contents and input (branch/jump redirect).
- `out_valid`  out  1  control bundle valid.
- `out_ready`  in  1  execute consumes the bundle.
- `out_pc`  out  PC_W  registered PC.
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each  register indices.
- `out_aluop`  out  5  ALU op.
- `out_rf_en`, `out_sel_b`, `out_is_load`, `out_mem_write`, `out_load_unsigned`  out  1 each  as named.
- `out_mem_size`  out  2  00 byte, 01 half, 10 word.
- `out_is_branch`, `out_is_jal`, `out_is_jalr`, `out_is_lui`, `out_is_auipc`  out  1 each  instruction class.
- `out_br_funct3`  out  3  branch condition.
- `out_illegal`  out  1  undecodable instruction.
- `hazard_stall`  out  1  interlock is blocking the input this cycle.

## Operation
- ALU op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASS_B (LUI).
  - 16–23 are reserved for the M extension (see Configuration).
- Decode follows RV32I:
  - R-type and I-ALU decode all ops listed above. I-shifts check `funct7`.
  - Loads: `mem_size = funct3[1:0]`, `load_unsigned = funct3[2]`. Stores: `mem_size = funct3[1:0]`.
  - Loads, stores, AUIPC and JALR use ADD with `sel_b=1`. Branches use SUB.
- Illegal instructions:
  - Triggers: `instr[1:0]!=2'b11`, unknown opcode, unknown funct combination, load funct3 ∈ {011,110,111}, store funct3 ≥ 011, branch funct3 ∈ {010,011}.
  - Response: `out_illegal=1` and `rf_en`, `mem_write`, `is_load`, `is_branch`, `is_jal`, `is_jalr` all 0. The bundle still issues.
- Register usage:
  - `rs1` is used by R, I-ALU, load, store, branch and JALR.
  - `rs2` is used by R, store and branch.
- Slot advance: `adv = !out_valid || out_ready`.
- Interlock state: `ld_rd[4:0]` and `cnt[1:0]`.
  - On `adv`, if a load with rd≠0 is accepted: `cnt<=LOAD_USE_BUBBLES`, `ld_rd<=rd`.
  - Otherwise, on `adv` with `cnt>0`: `cnt<=cnt-1`. This happens whether an independent instruction issues or a bubble is inserted.
- Dependence: the incoming instruction uses `ld_rd` as rs1 or rs2 while `cnt>0`. In that case `hazard_stall=1` and `in_ready=0`. On `adv` a bubble is issued (`out_valid<=0`).
- Ready rule: `in_ready = adv && !hazard_stall && !flush && !rst`.
- Flush:
  - Synchronous: `out_valid<=0`, `cnt<=0`, and the input is not accepted.
  - Flush overrides accept and stall.

## Timing
- Reset state:
  - All `out_*` are 0 and `cnt=0`.
  - `in_ready=0` while `rst` is high and 1 in the first cycle after release.
- Latency: 1 cycle. An instruction accepted at edge N drives `out_*` after edge N.
- Handshake:
  - `out_*` is held stable while `out_valid && !out_ready`.
  - Full throughput: 1 instruction per cycle when there is no hazard and `out_ready=1`.
- Downstream stall (`out_ready=0`): `cnt` does not decrement, so the bubble count is measured in issue slots, not cycles.
- Simultaneous accept of a load while `cnt>0`: the new load reloads `cnt` and `ld_rd`.
- Reset asserted mid-stall clears everything immediately, asynchronously.

## Configuration
- `RV32M_EN` defined: opcode 0110011 with funct7 0000001 decodes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU to `aluop` 16–23 with `rf_en=1`.
- `RV32M_EN` undefined: those encodings are illegal (`out_illegal=1`, `rf_en=0`).

## Test plan
- Reset, then issue `add x3,x1,x2` (0x002081B3) with `out_ready=1`:
  - after 1 cycle: `out_aluop=0`, `rf_en=1`, `rd=3`.
- `lw x5,0(x1)` followed by `add x6,x5,x2` with `LOAD_USE_BUBBLES=1`:
  - one cycle with `hazard_stall=1` and a bubble on `out_valid`;
  - the add issues on the following slot.
- `lw x5` then independent `addi x7,x0,1`, then `add x6,x5,x2`:
  - no bubble; `cnt` is consumed by the addi.
- `out_ready=0` for 3 cycles with a bundle held:
  - `out_*` stable and `in_ready=0`;
  - on release, issue resumes with no loss.
- `flush` asserted during a load-use stall:
  - next cycle `out_valid=0` and `cnt=0`;
  - the dependent instruction is then accepted with no bubble.
- MUL encoding 0x022081B3:
  - `RV32M_EN` defined: `aluop=16`.
  - `RV32M_EN` undefined: `out_illegal=1`, `rf_en=0`.
  - Also check 0x00000000: `out_illegal=1`.
